adder32_bit: RTL and testbench
==============================

Name: adder32_bit

Overview:
- Registered two's-complement/unsigned adder: s = a + b + cin, with carry-out; default width 32 bits.
- Combinational ripple-carry core built from a per-bit full-adder cell, followed by one output register stage with a valid flag.
- Used as a standalone arithmetic datapath block inside the adder-comparison designs.

Parameters:
- WIDTH, 32, operand and sum width in bits; legal range 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b/cin are valid this cycle
- a  input  WIDTH  operand A (unsigned or two's complement, same hardware)
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  s/cout hold a fresh result
- s  output  WIDTH  registered sum, low WIDTH bits of a+b+cin
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: on a rising clk edge with rst=1:
  - s <= 0, cout <= 0, out_valid <= 0.
  - rst takes priority over in_valid in the same cycle.
- Core is pure combinational ripple carry:
  - c[0] = cin.
  - s_i = a_i ^ b_i ^ c_i.
  - c[i+1] = a_i&b_i | a_i&c_i | b_i&c_i.
  - cout = c[WIDTH].
- Latency is exactly 1 cycle. On each edge with rst=0:
  - out_valid <= in_valid.
  - If in_valid=1, s and cout load the core result.
  - If in_valid=0, s and cout hold their previous values.
- No backpressure: a new operand set is accepted every cycle (throughput 1/cycle).
- Wrap-around: result is modulo 2^WIDTH.
  - cout is the unsigned carry and is not a signed-overflow indicator.
  - Example: 0x7FFFFFFF + 1 gives s = 0x80000000, cout = 0.
- The full 2^(2*WIDTH+1) input space is legal; no input combination is undefined.
- Reset asserted mid-stream discards the in-flight result; out_valid is 0 on the cycle after reset.

Optional Feature:
- Macro: ADDER32_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), the registered signed overflow c[WIDTH] ^ c[WIDTH-1].
  - ovf updates under the same in_valid/hold rules as s and cout.
  - ovf resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package adder_pkg holds:
  - localparam ADDER_W = 32.
  - typedef word_t (logic [ADDER_W-1:0]).
  - A result struct {cout, s}.
- One sub-module, full_adder_cell (a, b, ci -> s, co), instantiated WIDTH times in a generate loop.
- The top holds the carry chain wiring and the output register.

Test Plan (all with in_valid=1; check s/cout one cycle later; values in hex):
- 7FFFFFFF + 00000001, cin=0 -> s=80000000, cout=0 (ovf=1 if enabled).
- 80000000 + FFFFFFFF, cin=0 -> s=7FFFFFFF, cout=1 (ovf=1).
- 00000064 + FFFFFFCE (100 + -50), cin=0 -> s=00000032, cout=1 (ovf=0).
- FFFFFFE2 + FFFFFFEC (-30 + -20), cin=0 -> s=FFFFFFCE, cout=1.
- 0000000A + 0000000F, cin=1 -> s=0000001A, cout=0; then 0 + 0, cin=1 -> s=00000001, cout=0.
- Control checks:
  - rst=1 while in_valid=1 -> next cycle s=0, cout=0, out_valid=0.
  - in_valid=0 for 3 cycles -> out_valid=0 and s/cout hold.
  - Random back-to-back operands match a+b+cin against a reference model every cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the registered ripple-carry adder slice.
//   ADDER_W  : default operand/sum width
//   word_t   : one ADDER_W-bit operand or sum word
//   result_t : packed {cout, s} adder result
//   add_ref  : plain-arithmetic sum used wherever a quick golden value is handy
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int ADDER_W = 32;

   typedef logic [ADDER_W-1:0] word_t;

   typedef struct packed {
      logic  cout;
      word_t s;
   } result_t;

   // Full-width sum with carry-out, computed arithmetically
   function automatic result_t add_ref(input word_t a, input word_t b, input logic cin);
      logic [ADDER_W:0] wide;
      wide = {1'b0, a} + {1'b0, b} + {{ADDER_W{1'b0}}, cin};
      return result_t'(wide);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// One-bit full adder, the repeating cell of the ripple-carry chain.
// Ports:
//   a, b : operand bits
//   ci   : carry in from the next lower bit
//   s    : sum bit        (a ^ b ^ ci)
//   co   : carry out      (majority of a, b, ci)
// -----------------------------------------------------------------------------
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder32_bit.sv
// -----------------------------------------------------------------------------
// adder32_bit
// Registered adder: {cout, s} = a + b + cin, one cycle of latency, one new
// operand set accepted every cycle. The same hardware serves unsigned and
// two's-complement operands; the result wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH     : operand and sum width (>= 2), default ADDER_W (32)
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, wins over in_valid
//   in_valid  : a/b/cin carry a new operand set this cycle
//   a, b      : operands
//   cin       : carry in
//   out_valid : s/cout were loaded on the most recent edge
//   s         : registered sum
//   cout      : registered unsigned carry-out
//   ovf       : registered signed overflow (only with ADDER32_OVERFLOW_EN)
//
// Build option: define ADDER32_OVERFLOW_EN to add the ovf output.
// -----------------------------------------------------------------------------
module adder32_bit
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
`ifdef ADDER32_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             cout
);

   // carry_s[i] is the carry into bit i; carry_s[WIDTH] is the carry-out
   logic [WIDTH:0]   carry_s;
   logic [WIDTH-1:0] sum_s;

   logic             out_valid_r;
   logic [WIDTH-1:0] s_r;
   logic             cout_r;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_cell u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry_s[i]),
         .s  (sum_s[i]),
         .co (carry_s[i+1])
      );
   end

   // Output stage: load on in_valid, otherwise hold; valid tracks in_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         s_r         <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
      end else begin
         out_valid_r <= in_valid;
         if (in_valid) begin
            s_r    <= sum_s;
            cout_r <= carry_s[WIDTH];
         end else begin
            s_r    <= s_r;
            cout_r <= cout_r;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign s         = s_r;
   assign cout      = cout_r;

`ifdef ADDER32_OVERFLOW_EN
   // Signed overflow: carry into the sign bit differs from carry out of it
   logic ovf_r;

   // Overflow flag register, same load/hold rules as the sum
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (in_valid) begin
         ovf_r <= carry_s[WIDTH] ^ carry_s[WIDTH-1];
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_adder32_bit.sv
// -----------------------------------------------------------------------------
// tb_adder32_bit
// Self-checking bench for adder32_bit (WIDTH = 32): directed vector table,
// reset and hold sequences, then randomized back-to-back traffic compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_adder32_bit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: what the registered outputs should currently hold
   logic [W-1:0] exp_s;
   logic         exp_cout;
   logic         exp_ovf;

   always #5 clk = ~clk;

   adder32_bit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .s         (s),
`ifdef ADDER32_OVERFLOW_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

`ifndef ADDER32_OVERFLOW_EN
   assign ovf = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, sample just after the rising edge
   task automatic step(input logic r, input logic v, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c);
      @(negedge clk);
      rst = r; in_valid = v; a = aa; b = bb; cin = c;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer addition, signed overflow from operand signs
   task automatic model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
      logic [W:0] wide;
      wide     = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
      exp_s    = wide[W-1:0];
      exp_cout = wide[W];
      exp_ovf  = (aa[W-1] == bb[W-1]) && (wide[W-1] != aa[W-1]);
   endtask

   task automatic check_outputs(input string tag, input logic v);
      check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
      check({tag, ".s"},         {32'd0, s},         {32'd0, exp_s});
      check({tag, ".cout"},      {63'd0, cout},      {63'd0, exp_cout});
`ifdef ADDER32_OVERFLOW_EN
      check({tag, ".ovf"},       {63'd0, ovf},       {63'd0, exp_ovf});
`endif
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[2] = '{32'h0000_0064, 32'hFFFF_FFCE, 1'b0, 32'h0000_0032, 1'b1, 1'b0};
      vecs[3] = '{32'hFFFF_FFE2, 32'hFFFF_FFEC, 1'b0, 32'hFFFF_FFCE, 1'b1, 1'b0};
      vecs[4] = '{32'h0000_000A, 32'h0000_000F, 1'b1, 32'h0000_001A, 1'b0, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

      // Reset with live operands on the inputs: registers must still clear
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      exp_s = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      check_outputs("reset", 1'b0);

      // Directed vector table, back to back
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
         exp_s = vecs[i].s; exp_cout = vecs[i].cout; exp_ovf = vecs[i].ovf;
         check_outputs($sformatf("vec%0d", i), 1'b1);
      end

      // Load a carry-out result, then idle 3 cycles with changing operands
      step(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_outputs("hold_load", 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, $urandom, $urandom, 1'($urandom_range(1)));
         check_outputs($sformatf("hold%0d", i), 1'b0);
      end

      // Reset mid-stream while in_valid is high discards the operand set
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      model(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      check_outputs("pre_rst", 1'b1);
      step(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      exp_s = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      check_outputs("mid_rst", 1'b0);
      step(1'b0, 1'b0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
      check_outputs("post_rst_idle", 1'b0);

      // Random back-to-back traffic, every cycle valid
      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
         step(1'b0, 1'b1, ra, rb, rc);
         model(ra, rb, rc);
         check_outputs("rand_b2b", 1'b1);
      end

      // Random traffic with gaps in in_valid
      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc, rv;
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
         rv = 1'($urandom_range(1));
         if (i % 7 == 0) begin
            rb = ~ra;   // exercise full-length carry propagation
         end
         step(1'b0, rv, ra, rb, rc);
         if (rv) begin
            model(ra, rb, rc);
         end
         check_outputs("rand_gap", rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
